// File: rtl/step_dir_monitor.sv
// Step/dir receiver: filters the step line, tracks absolute position and
// per-move statistics (step count, step interval, move start/end events).
module step_dir_monitor #(
  parameter int unsigned POS_WIDTH    = 16,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned MIN_HIGH     = 1,
  parameter int unsigned IDLE_TIMEOUT = 20000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_in,
  input  logic                 dir_in,
  input  logic                 zero_pos,
  output logic [POS_WIDTH-1:0] position,
  output logic                 step_pulse,
  output logic                 dir_out,
  output logic                 moving,
  output logic                 move_done,
  output logic [CNT_WIDTH-1:0] move_steps,
  output logic [CNT_WIDTH-1:0] last_interval,
  output logic                 interval_valid,
  output logic                 glitch
);

  localparam int unsigned HW = $clog2(MIN_HIGH) + 1;
  localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [HW-1:0] HI_LAST = HW'(MIN_HIGH - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ARM      = 2'd1;
  localparam logic [1:0] S_WAIT_LOW = 2'd2;
  localparam logic [1:0] S_GAP      = 2'd3;

  logic                 step_q1, step_s, dir_q1, dir_s;
  logic [1:0]           state_q, state_d;
  logic [HW-1:0]        hi_cnt_q, hi_cnt_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic                 dir_out_q, dir_out_d;
  logic                 moving_q, moving_d;
  logic                 move_done_q, step_pulse_q, glitch_q, glitch_d;
  logic [CNT_WIDTH-1:0] move_steps_q, move_steps_d;
  logic [CNT_WIDTH-1:0] last_int_q, last_int_d;
  logic                 ivalid_q, ivalid_d;
  logic [CNT_WIDTH-1:0] gap_q, gap_d;
  logic [TW-1:0]        idle_q, idle_d;
  logic                 accept, timeout, to_rest;
  logic [POS_WIDTH-1:0] pos_base;

  always_comb begin
    accept   = 1'b0;
    glitch_d = 1'b0;
    to_rest  = 1'b0;
    state_d  = state_q;
    hi_cnt_d = hi_cnt_q;

    unique case (state_q)
      S_IDLE, S_GAP: begin
        if (step_s) begin
          if (MIN_HIGH == 1) begin
            accept  = 1'b1;
            state_d = S_WAIT_LOW;
          end else begin
            state_d  = S_ARM;
            hi_cnt_d = HW'(1);
          end
        end
      end
      S_ARM: begin
        if (!step_s) begin
          glitch_d = 1'b1;
          to_rest  = 1'b1;
        end else if (hi_cnt_q == HI_LAST) begin
          accept  = 1'b1;
          state_d = S_WAIT_LOW;
        end else begin
          hi_cnt_d = hi_cnt_q + 1'b1;
        end
      end
      default: begin
        if (!step_s) to_rest = 1'b1;
      end
    endcase

    // An accept on the timeout cycle wins: the move simply continues.
    timeout  = moving_q && !accept && (idle_q == T_LAST);
    moving_d = accept ? 1'b1 : (timeout ? 1'b0 : moving_q);
    if (to_rest) state_d = moving_d ? S_GAP : S_IDLE;

    idle_d = (accept || timeout || !moving_q) ? '0 : idle_q + 1'b1;

    if (accept)                           gap_d = CNT_WIDTH'(1);
    else if (moving_q && gap_q != CNT_MAX) gap_d = gap_q + 1'b1;
    else                                  gap_d = gap_q;

    // zero_pos clears first, then a coincident step is applied on top.
    pos_base = zero_pos ? '0 : pos_q;
    pos_d    = pos_base;
    if (accept) pos_d = dir_s ? pos_base + 1'b1 : pos_base - 1'b1;

    dir_out_d    = accept ? dir_s : dir_out_q;
    move_steps_d = move_steps_q;
    last_int_d   = last_int_q;
    ivalid_d     = ivalid_q;
    if (accept) begin
      if (!moving_q) begin
        move_steps_d = CNT_WIDTH'(1);
        ivalid_d     = 1'b0;
      end else begin
        if (move_steps_q != CNT_MAX) move_steps_d = move_steps_q + 1'b1;
        last_int_d = gap_q;
        ivalid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Step sync resets high so a line held high across reset is not a step.
      step_q1      <= 1'b1;
      step_s       <= 1'b1;
      dir_q1       <= 1'b0;
      dir_s        <= 1'b0;
      state_q      <= S_WAIT_LOW;
      hi_cnt_q     <= '0;
      pos_q        <= '0;
      dir_out_q    <= 1'b0;
      moving_q     <= 1'b0;
      move_done_q  <= 1'b0;
      step_pulse_q <= 1'b0;
      glitch_q     <= 1'b0;
      move_steps_q <= '0;
      last_int_q   <= '0;
      ivalid_q     <= 1'b0;
      gap_q        <= '0;
      idle_q       <= '0;
    end else begin
      step_q1      <= step_in;
      step_s       <= step_q1;
      dir_q1       <= dir_in;
      dir_s        <= dir_q1;
      state_q      <= state_d;
      hi_cnt_q     <= hi_cnt_d;
      pos_q        <= pos_d;
      dir_out_q    <= dir_out_d;
      moving_q     <= moving_d;
      move_done_q  <= timeout;
      step_pulse_q <= accept;
      glitch_q     <= glitch_d;
      move_steps_q <= move_steps_d;
      last_int_q   <= last_int_d;
      ivalid_q     <= ivalid_d;
      gap_q        <= gap_d;
      idle_q       <= idle_d;
    end
  end

  assign position       = pos_q;
  assign step_pulse     = step_pulse_q;
  assign dir_out        = dir_out_q;
  assign moving         = moving_q;
  assign move_done      = move_done_q;
  assign move_steps     = move_steps_q;
  assign last_interval  = last_int_q;
  assign interval_valid = ivalid_q;
  assign glitch         = glitch_q;

endmodule

// File: tb/tb_step_dir_monitor.sv
// Randomized bench for step_dir_monitor against an event-level reference model.
module tb_step_dir_monitor;
  localparam int MH = 3;
  localparam int T  = 200;

  logic        clk = 1'b0;
  logic        reset, step_in, dir_in, zero_pos;
  logic [15:0] position, move_steps, last_interval;
  logic        step_pulse, dir_out, moving, move_done, interval_valid, glitch;

  step_dir_monitor #(
    .POS_WIDTH(16), .CNT_WIDTH(16), .MIN_HIGH(MH), .IDLE_TIMEOUT(T)
  ) dut (
    .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
    .zero_pos(zero_pos), .position(position), .step_pulse(step_pulse),
    .dir_out(dir_out), .moving(moving), .move_done(move_done),
    .move_steps(move_steps), .last_interval(last_interval),
    .interval_valid(interval_valid), .glitch(glitch)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: state after the most recent edge, edge counter e.
  int          e = 0;
  logic [15:0] m_pos;
  bit          m_dir, m_moving, m_ivalid;
  int          m_steps, m_interval, m_last_a;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, e, got, exp);
    end
  endtask

  task automatic compare_all(input bit exp_acc, input bit exp_done, input bit exp_glt);
    check("step_pulse", int'(step_pulse), int'(exp_acc));
    check("move_done", int'(move_done), int'(exp_done));
    check("glitch", int'(glitch), int'(exp_glt));
    check("moving", int'(moving), int'(m_moving));
    check("position", int'(position), int'(m_pos));
    check("move_steps", int'(move_steps), m_steps);
    check("last_interval", int'(last_interval), m_interval);
    check("interval_valid", int'(interval_valid), int'(m_ivalid));
    check("dir_out", int'(dir_out), int'(m_dir));
  endtask

  task automatic model_reset();
    m_pos = '0; m_dir = 0; m_moving = 0; m_ivalid = 0;
    m_steps = 0; m_interval = 0; m_last_a = 0;
  endtask

  task automatic do_reset(input bit level);
    reset = 1'b1; step_in = level; dir_in = 1'b0; zero_pos = 1'b0;
    repeat (3) @(posedge clk);
    e += 3;
    model_reset();
    #1;
    compare_all(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // One clock: drive inputs, advance the model by the rules, compare.
  task automatic tick(input bit s, input bit d, input bit z, input bit acc, input bit glt);
    bit done;
    step_in = s; dir_in = d; zero_pos = z;
    @(posedge clk);
    e++;
    done = 1'b0;
    if (z) m_pos = '0;
    if (acc) begin
      m_pos = d ? m_pos + 16'd1 : m_pos - 16'd1;
      m_dir = d;
      if (m_moving) begin
        m_steps    = (m_steps == 65535) ? 65535 : m_steps + 1;
        m_interval = e - m_last_a;
        m_ivalid   = 1'b1;
      end else begin
        m_steps  = 1;
        m_ivalid = 1'b0;
        m_moving = 1'b1;
      end
      m_last_a = e;
    end else if (m_moving && (e - m_last_a == T)) begin
      m_moving = 1'b0;
      done     = 1'b1;
    end
    #1;
    compare_all(acc, done, glt);
  endtask

  // A high pulse of l samples then g low samples. A pulse of at least MH
  // samples is accepted MH+1 edges after its first sample; a shorter one
  // is reported as a glitch 2+l edges after its first sample.
  task automatic pulse(input int l, input int g, input bit d, input int zmode);
    int acc_idx, glt_idx, z_idx;
    acc_idx = (l >= MH) ? 1 + MH : -1;
    glt_idx = (l < MH) ? 2 + l : -1;
    z_idx   = -1;
    if (zmode == 1) z_idx = acc_idx;
    else if (zmode == 2) z_idx = $urandom_range(l + g - 1, 0);
    for (int i = 0; i < l + g; i++)
      tick(i < l, d, i == z_idx, i == acc_idx, i == glt_idx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, dir_in, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; step_in = 1'b0; dir_in = 1'b0; zero_pos = 1'b0;
    model_reset();

    // Long forward move, then timeout.
    do_reset(1'b0);
    idle(5);
    for (int i = 0; i < 50; i++) pulse(3, 98, 1'b1, 0);
    check("t1_pos", int'(position), 50);
    check("t1_steps", int'(move_steps), 50);
    check("t1_interval", int'(last_interval), 101);
    check("t1_ivalid", int'(interval_valid), 1);
    idle(T + 20);
    check("t1_moving_end", int'(moving), 0);

    // Reverse steps wrap below zero, then zero strobe.
    do_reset(1'b0);
    idle(5);
    for (int i = 0; i < 3; i++) pulse(4, 10, 1'b0, 0);
    check("t2_pos", int'(position), 16'hFFFD);
    check("t2_dir", int'(dir_out), 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t2_zero", int'(position), 0);

    // Glitch filter.
    pulse(2, 10, 1'b1, 0);
    pulse(1, 10, 1'b1, 0);
    check("t3_pos_glitch", int'(position), 0);
    pulse(3, 10, 1'b1, 0);
    check("t3_pos_step", int'(position), 1);

    // zero_pos coincident with an accept.
    do_reset(1'b0);
    idle(5);
    for (int i = 0; i < 40; i++) pulse(3, 5, 1'b1, 0);
    check("t4_pos40", int'(position), 40);
    pulse(3, 10, 1'b1, 1);
    check("t4_pos", int'(position), 1);

    // Step held high across reset is ignored until it toggles.
    do_reset(1'b1);
    for (int i = 0; i < 100; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(5);
    pulse(3, 10, 1'b1, 0);
    check("t5_steps", int'(move_steps), 1);
    check("t5_pos", int'(position), 1);

    // Second accept lands exactly on the timeout cycle.
    do_reset(1'b0);
    idle(5);
    pulse(3, T - 3, 1'b1, 0);
    pulse(3, 10, 1'b1, 0);
    check("t6_moving", int'(moving), 1);
    check("t6_steps", int'(move_steps), 2);
    check("t6_interval", int'(last_interval), T);
    idle(T + 10);

    // Random pulses, gaps, directions, zero strobes and resets.
    for (int n = 0; n < 150; n++) begin
      int zm;
      zm = $urandom_range(9, 0);
      zm = (zm == 0) ? 1 : ((zm == 1) ? 2 : 0);
      if ($urandom_range(39, 0) == 0) begin
        do_reset(1'b0);
        idle(5);
      end
      pulse($urandom_range(6, 1), $urandom_range(260, 4), 1'($urandom_range(1, 0)), zm);
    end
    idle(T + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
